s1494_state_seq: RTL

Sequential state stage for the combinationalized s1494 slices. Holds the six present-state bits v7..v12 and the registered primary inputs v0..v6 that feed the partial-output next-state cones (n55 and siblings). Each accepted step captures the cone results back into the state register. Sits directly upstream and downstream of the cones, closing the loop so that the combinational slices execute as the original sequential machine.

---
 rtl/s1494_state_seq.sv | 102 ++++++++++
 1 files changed

// File: rtl/s1494_state_seq.sv
// State and primary-input register stage closing the loop around the s1494 next-state cones.
// Optional serial scan through the state bits is enabled by defining S1494_SCAN_EN.
module s1494_state_seq #(
    parameter int STATE_W = 6,
    parameter int PI_W    = 7,
    parameter int CNT_W   = 16
) (
    input  logic               CK,
    input  logic               RST,
    input  logic               step_valid,
    output logic               step_ready,
    input  logic [PI_W-1:0]    pi_in,
    output logic [PI_W-1:0]    pi_q,
    output logic [STATE_W-1:0] state,
    input  logic [STATE_W-1:0] ns,
    output logic               done,
    output logic [CNT_W-1:0]   step_cnt,
    input  logic               scan_en,
    input  logic               scan_in,
    output logic               scan_out
);

    typedef enum logic {
        IDLE = 1'b0,
        EVAL = 1'b1
    } fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [PI_W-1:0]    pi_reg_q, pi_reg_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               scan_active;
    logic [STATE_W-1:0] state_shifted;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

`ifdef S1494_SCAN_EN
    assign scan_active   = scan_en;
    assign state_shifted = {state_q[STATE_W-2:0], scan_in};
    assign scan_out      = state_q[STATE_W-1];
`else
    // Scan pins stay on the interface but have no effect in this build.
    logic scan_unused;
    assign scan_unused   = scan_en ^ scan_in;
    assign scan_active   = 1'b0;
    assign state_shifted = state_q;
    assign scan_out      = 1'b0;
`endif

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            fsm_q    <= IDLE;
            state_q  <= '0;
            pi_reg_q <= '0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            pi_reg_q <= pi_reg_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        pi_reg_d = pi_reg_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        unique case (fsm_q)
            IDLE: begin
                if (scan_active) begin
                    state_d = state_shifted;
                end else if (step_valid) begin
                    pi_reg_d = pi_in;
                    fsm_d    = EVAL;
                end
            end
            EVAL: begin
                // Cones have had a full cycle to settle from pi_q and state.
                state_d = ns;
                done_d  = 1'b1;
                cnt_d   = sat_inc(cnt_q);
                fsm_d   = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign step_ready = (fsm_q == IDLE) & ~scan_active;
    assign pi_q       = pi_reg_q;
    assign state      = state_q;
    assign done       = done_q;
    assign step_cnt   = cnt_q;

endmodule
